digital_clock_scan: RTL and testbench
=====================================

Name: digital_clock_scan

Overview:
- Parametrised 24-hour clock (HH:MM:SS) with an internal 1 Hz prescaler and a time-set mode driven by mode/increment buttons.
- Selectable 12/24-hour display.
- Drives a six-digit multiplexed 7-segment display with configurable segment and digit polarity, instead of static per-digit BCD outputs.
- Sits between the board clock/buttons and the display pins.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per one-second tick (>=4).
- SCAN_DIV, 50_000: clk cycles per digit scan slot (>=1).
- SEG_ACT_LOW, 0: 1 inverts seg outputs (common-anode).
- DIG_ACT_LOW, 0: 1 inverts dig_sel outputs.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-low reset.
- btn_mode  in  1  single-cycle pulse, pre-debounced; advances set-mode state.
- btn_inc  in  1  single-cycle pulse, pre-debounced; increments selected field.
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- seg  out  7  segments, bit6=a … bit0=g.
- dig_sel  out  6  one-hot digit enable; bit0 = seconds units … bit5 = hours tens.
- time_bcd  out  24  {hr_t, hr_u, mn_t, mn_u, sc_t, sc_u}, always 24-hour.
- pm  out  1  hour >= 12 (valid in both modes).
- set_state  out  2  0 RUN, 1 SET_HOUR, 2 SET_MIN.
- hour_pulse  out  1  one-cycle pulse on each RUN rollover of mm:ss from 59:59 to 00:00.

Behaviour:
- Reset: clk is the single clock; clr is asynchronous, active-low. Reset values:
  - sec = min = hour = 0, prescaler = 0, scan counter = 0, digit index = 0, set_state = RUN.
  - seg all-off and dig_sel all-inactive (polarity applied).
  - hour_pulse = 0, pm = 0, time_bcd = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 then wraps.
  - tick = 1 in the cycle where count == TICK_DIV-1.
  - blink = (count >= TICK_DIV/2).
- RUN state:
  - On tick, sec increments. sec 59 -> 0 carries to min; min 59 -> 0 carries to hour; hour 23 -> 0.
  - hour_pulse is asserted in the same cycle the registers wrap mm:ss to 00:00.
- State machine, driven by btn_mode:
  - RUN -> SET_HOUR, and sec is cleared to 0 in the same cycle.
  - SET_HOUR -> SET_MIN.
  - SET_MIN -> RUN, and the prescaler is reset to 0, so the first tick occurs TICK_DIV cycles later.
- Set modes:
  - In SET_HOUR/SET_MIN, ticks are ignored (time frozen); the prescaler keeps running for blink.
  - btn_inc in SET_HOUR: hour = (hour+1) mod 24.
  - btn_inc in SET_MIN: min = (min+1) mod 60, with no carry into hour.
  - btn_inc in RUN is ignored.
  - btn_mode and btn_inc in the same cycle: mode wins, inc is dropped.
- Display digits (combinational from registers):
  - 24h: hours digits = hour/10, hour%10.
  - 12h: displayed hour = 12 if hour==0 or hour==12, else hour mod 12. The hours-tens digit is blanked when it is 0.
  - Minutes and seconds are always shown in decimal. time_bcd is unaffected by mode_12h.
- Blink: while blink==1, the two digits of the field selected for setting are blanked (hours in SET_HOUR, minutes in SET_MIN).
- Scan:
  - Scan counter wraps at SCAN_DIV-1; on wrap, digit index advances 0..5 -> 0.
  - seg and dig_sel are registered: one cycle latency from digit index/time change to pins.
  - After reset, the first registered update is the cycle after clr deasserts, showing digit 0.
- Segment encoding (active-high before inversion):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Blank or invalid = 0000000.
- Reset mid-operation (any state, mid-scan, mid-set): returns immediately to reset values. No partial increment survives.

Decomposition:
- Shared package clock_pkg:
  - set-state enum (RUN/SET_HOUR/SET_MIN).
  - segment pattern constants for 0-9 and blank.
  - limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
- One sub-module seg7_decoder:
  - Inputs: 4-bit BCD, blank flag, ACT_LOW parameter.
  - Output: 7-bit seg pattern.
  - Combinational.
- Top instantiates it once on the muxed digit.

Test Plan (TICK_DIV=4, SCAN_DIV=2):
- Reset then run 60*4 cycles -> time_bcd = 00:01:00. hour_pulse never asserted. Assert clr mid-count -> all outputs return to reset values asynchronously.
- Preload 23:59:59 via set mode, return to RUN, wait one tick:
  - set to 23:59, then RUN advances to 23:59:59.
  - on the next tick, time_bcd = 00:00:00 and hour_pulse is high for exactly 1 cycle.
- Set-mode editing:
  - btn_mode at 10:20:37 -> sec = 0, set_state = 1.
  - 15 btn_inc -> hour = 1 (wrap 23->0).
  - btn_mode, then 45 btn_inc from min 20 -> min = 5, hour unchanged.
  - btn_mode -> RUN; first tick exactly 4 cycles later.
- mode_12h=1 with hour = 0, 12, 13, 9:
  - displayed hours = 12, 12, 1, blank+9.
  - pm = 0, 1, 1, 0.
  - time_bcd hours stay 00/12/13/09.
- Scan and polarity: SEG_ACT_LOW=1, DIG_ACT_LOW=1, time 00:00:08:
  - dig_sel cycles 111110 -> 111101 -> … -> 011111, each for 2 cycles.
  - seg = 0000000 when dig_sel = 111110 (digit 8).
- Simultaneous btn_mode+btn_inc in SET_HOUR -> state becomes SET_MIN, hour unchanged. In SET_MIN with blink=1, minute digits show seg all-off.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the multiplexed HH:MM:SS display clock.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } set_state_e;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    // Segment patterns, bit6 = a ... bit0 = g, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Binary 0..59 to packed {tens, units} BCD.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 6'd10);
        u = 4'(v - 6'(t) * 6'd10);
        return {t, u};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to 7-segment pattern with blanking and selectable output polarity.
module seg7_decoder
    import clock_pkg::*;
#(
    parameter int ACT_LOW = 0
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] pat;

    always_comb begin
        pat = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    pat = SEG_0;
                4'd1:    pat = SEG_1;
                4'd2:    pat = SEG_2;
                4'd3:    pat = SEG_3;
                4'd4:    pat = SEG_4;
                4'd5:    pat = SEG_5;
                4'd6:    pat = SEG_6;
                4'd7:    pat = SEG_7;
                4'd8:    pat = SEG_8;
                4'd9:    pat = SEG_9;
                default: pat = SEG_BLANK;
            endcase
        end
        seg = (ACT_LOW != 0) ? ~pat : pat;
    end

endmodule

// File: rtl/digital_clock_scan.sv
// 24-hour HH:MM:SS clock with button time-set and a six-digit multiplexed
// 7-segment driver (optional 12-hour display, blinking edit field).
module digital_clock_scan
    import clock_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SCAN_DIV    = 50_000,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        mode_12h,
    output logic [6:0]  seg,
    output logic [5:0]  dig_sel,
    output logic [23:0] time_bcd,
    output logic        pm,
    output logic [1:0]  set_state,
    output logic        hour_pulse
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] BLINK_START = TICK_W'(TICK_DIV / 2);
    localparam logic [SCAN_W-1:0] SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [6:0]        SEG_OFF     = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [5:0]        DIG_OFF     = (DIG_ACT_LOW != 0) ? 6'h3F : 6'h00;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        dig_idx_q, dig_idx_d;
    logic [5:0]        sec_q, sec_d;
    logic [5:0]        min_q, min_d;
    logic [4:0]        hour_q, hour_d;
    set_state_e        state_q, state_d;
    logic              hour_pulse_q, hour_pulse_d;
    logic [6:0]        seg_q, seg_d;
    logic [5:0]        dig_sel_q, dig_sel_d;

    logic              tick;
    logic              blink;
    logic [7:0]        hr_bcd, mn_bcd, sc_bcd;
    logic [4:0]        hour_disp;
    logic [7:0]        hr_disp_bcd;
    logic              hr_tens_blank;
    logic [3:0]        digit_bcd;
    logic              digit_blank;
    logic [6:0]        seg_pat;

    assign tick  = (tick_cnt_q == TICK_LAST);
    assign blink = (tick_cnt_q >= BLINK_START);

    // Timekeeping and set-mode state machine
    always_comb begin
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
        sec_d        = sec_q;
        min_d        = min_q;
        hour_d       = hour_q;
        state_d      = state_q;
        hour_pulse_d = 1'b0;
        case (state_q)
            RUN: begin
                if (btn_mode) begin
                    state_d = SET_HOUR;
                    sec_d   = '0;
                end else if (tick) begin
                    if (sec_q == SEC_MAX) begin
                        sec_d = '0;
                        if (min_q == MIN_MAX) begin
                            min_d        = '0;
                            hour_pulse_d = 1'b1;
                            hour_d       = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
                        end else begin
                            min_d = min_q + 1'b1;
                        end
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end
            end
            SET_HOUR: begin
                if (btn_mode) begin
                    state_d = SET_MIN;
                end else if (btn_inc) begin
                    hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
                end
            end
            SET_MIN: begin
                // Restart the prescaler so the first second after editing is a full one.
                if (btn_mode) begin
                    state_d    = RUN;
                    tick_cnt_d = '0;
                end else if (btn_inc) begin
                    min_d = (min_q == MIN_MAX) ? '0 : min_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        hr_bcd = to_bcd({1'b0, hour_q});
        mn_bcd = to_bcd(min_q);
        sc_bcd = to_bcd(sec_q);

        if (hour_q == 5'd0) begin
            hour_disp = 5'd12;
        end else if (hour_q > 5'd12) begin
            hour_disp = hour_q - 5'd12;
        end else begin
            hour_disp = hour_q;
        end
        hr_disp_bcd   = mode_12h ? to_bcd({1'b0, hour_disp}) : hr_bcd;
        hr_tens_blank = mode_12h && (hr_disp_bcd[7:4] == 4'd0);
    end

    // Digit select for the current scan slot, including edit-field blink
    always_comb begin
        digit_bcd   = 4'd0;
        digit_blank = 1'b0;
        case (dig_idx_q)
            3'd0: digit_bcd = sc_bcd[3:0];
            3'd1: digit_bcd = sc_bcd[7:4];
            3'd2: begin
                digit_bcd   = mn_bcd[3:0];
                digit_blank = (state_q == SET_MIN) && blink;
            end
            3'd3: begin
                digit_bcd   = mn_bcd[7:4];
                digit_blank = (state_q == SET_MIN) && blink;
            end
            3'd4: begin
                digit_bcd   = hr_disp_bcd[3:0];
                digit_blank = (state_q == SET_HOUR) && blink;
            end
            3'd5: begin
                digit_bcd   = hr_disp_bcd[7:4];
                digit_blank = ((state_q == SET_HOUR) && blink) || hr_tens_blank;
            end
            default: digit_blank = 1'b1;
        endcase
    end

    seg7_decoder #(
        .ACT_LOW(SEG_ACT_LOW)
    ) u_seg7 (
        .bcd  (digit_bcd),
        .blank(digit_blank),
        .seg  (seg_pat)
    );

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        dig_idx_d  = dig_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 1'b1;
        end
        seg_d     = seg_pat;
        dig_sel_d = DIG_OFF ^ (6'b000001 << dig_idx_q);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tick_cnt_q   <= '0;
            scan_cnt_q   <= '0;
            dig_idx_q    <= '0;
            sec_q        <= '0;
            min_q        <= '0;
            hour_q       <= '0;
            state_q      <= RUN;
            hour_pulse_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_sel_q    <= DIG_OFF;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
            dig_idx_q    <= dig_idx_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            state_q      <= state_d;
            hour_pulse_q <= hour_pulse_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign time_bcd   = {hr_bcd, mn_bcd, sc_bcd};
    assign pm         = (hour_q >= 5'd12);
    assign set_state  = state_q;
    assign hour_pulse = hour_pulse_q;

endmodule

// File: tb/tb_digital_clock_scan.sv
// Scoreboard bench for digital_clock_scan: a behavioural clock model queues the
// expected pin state per clock edge, and the queue is drained on the falling edge.
module tb_digital_clock_scan;

    localparam int TICK = 4;
    localparam int SCAN = 2;

    logic        clk;
    logic        clr;
    logic        btn_mode;
    logic        btn_inc;
    logic        mode_12h;
    logic [6:0]  seg;
    logic [5:0]  dig_sel;
    logic [23:0] time_bcd;
    logic        pm;
    logic [1:0]  set_state;
    logic        hour_pulse;

    digital_clock_scan #(
        .TICK_DIV   (TICK),
        .SCAN_DIV   (SCAN),
        .SEG_ACT_LOW(1),
        .DIG_ACT_LOW(1)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .mode_12h  (mode_12h),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .time_bcd  (time_bcd),
        .pm        (pm),
        .set_state (set_state),
        .hour_pulse(hour_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] tbcd;
        logic [1:0]  st;
        logic        pm;
        logic        hp;
        logic [6:0]  seg;
        logic [5:0]  dig;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   hp_cnt = 0;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1111011};

    // Reference model state
    int         mh, mm, ms, mst, mcnt, mscan, midx;
    logic       mpulse, mblink_seg;
    logic [6:0] mseg;
    logic [5:0] mdig;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mh = 0; mm = 0; ms = 0; mst = 0; mcnt = 0; mscan = 0; midx = 0;
        mpulse = 1'b0; mblink_seg = 1'b0;
        mseg = 7'h7F; mdig = 6'h3F;
        sb_q.delete();
    endtask

    task automatic model_edge();
        int tick_now, blink_now, dh, dv, nxt;
        logic bl;
        logic [5:0] onehot;
        tick_now  = (mcnt == TICK - 1);
        blink_now = (mcnt >= TICK / 2);
        dh = mode_12h ? ((mh % 12 == 0) ? 12 : mh % 12) : mh;
        bl = 1'b0;
        dv = 0;
        case (midx)
            0: dv = ms % 10;
            1: dv = ms / 10;
            2: begin dv = mm % 10; bl = (mst == 2) && blink_now; end
            3: begin dv = mm / 10; bl = (mst == 2) && blink_now; end
            4: begin dv = dh % 10; bl = (mst == 1) && blink_now; end
            default: begin
                dv = dh / 10;
                bl = ((mst == 1) && blink_now) || (mode_12h && dh < 10);
            end
        endcase
        mseg = (bl ? 7'h00 : seg_tab[dv]) ^ 7'h7F;
        mblink_seg = blink_now[0];
        onehot = 6'b000001 << midx;
        mdig = ~onehot;
        mpulse = 1'b0;
        nxt = (mcnt + 1) % TICK;
        if (mst == 0) begin
            if (btn_mode) begin
                mst = 1; ms = 0;
            end else if (tick_now) begin
                ms++;
                if (ms == 60) begin
                    ms = 0; mm++;
                    if (mm == 60) begin
                        mm = 0; mh = (mh + 1) % 24; mpulse = 1'b1;
                    end
                end
            end
        end else if (mst == 1) begin
            if (btn_mode) mst = 2;
            else if (btn_inc) mh = (mh + 1) % 24;
        end else begin
            if (btn_mode) begin
                mst = 0; nxt = 0;
            end else if (btn_inc) mm = (mm + 1) % 60;
        end
        mcnt = nxt;
        mscan++;
        if (mscan == SCAN) begin
            mscan = 0;
            midx = (midx + 1) % 6;
        end
    endtask

    function automatic logic [23:0] model_bcd();
        return {4'(mh / 10), 4'(mh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ms / 10), 4'(ms % 10)};
    endfunction

    // One clock: model advances and queues its expectation at the rising edge,
    // the DUT pins are compared against it at the falling edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.tbcd = model_bcd();
        e.st   = 2'(mst);
        e.pm   = (mh >= 12);
        e.hp   = mpulse;
        e.seg  = mseg;
        e.dig  = mdig;
        sb_q.push_back(e);
        @(negedge clk);
        if (hour_pulse === 1'b1) hp_cnt++;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("time_bcd", time_bcd, e.tbcd);
            chk("set_state", set_state, e.st);
            chk("pm", pm, e.pm);
            chk("hour_pulse", hour_pulse, e.hp);
            chk("seg", seg, e.seg);
            chk("dig_sel", dig_sel, e.dig);
        end
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_seg"}, seg, 7'h7F);
        chk({tag, "_dig"}, dig_sel, 6'h3F);
        chk({tag, "_tbcd"}, time_bcd, 24'h000000);
        chk({tag, "_pm"}, pm, 1'b0);
        chk({tag, "_hp"}, hour_pulse, 1'b0);
        chk({tag, "_st"}, set_state, 2'd0);
    endtask

    // Edit hour to target and return to RUN (minutes untouched, seconds cleared).
    task automatic go_hour(input int target);
        press(1'b1, 1'b0);
        repeat ((target - mh + 24) % 24) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
    endtask

    task automatic wait_digit(input int k);
        logic [5:0] want;
        logic found;
        want  = ~(6'b000001 << k);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (dig_sel === want) found = 1'b1;
            else step();
        end
        if (!found) chk("scan_timeout", dig_sel, want);
    endtask

    task automatic check_12h(input int hr, input logic [6:0] tens, input logic [6:0] units,
                             input logic exp_pm, input logic [7:0] hr_bcd);
        go_hour(hr);
        step();
        chk("pm_12h", pm, exp_pm);
        chk("tbcd_hr_12h", time_bcd[23:16], hr_bcd);
        wait_digit(5);
        chk("hr_tens_12h", seg, tens);
        wait_digit(4);
        chk("hr_units_12h", seg, units);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nblank;
        logic [5:0] want;
        clr      = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        mode_12h = 1'b0;
        model_reset();

        // Reset values, then one minute of running
        #12;
        check_reset_pins("rst");
        @(negedge clk);
        clr = 1'b1;
        repeat (60 * TICK) step();
        chk("one_minute", time_bcd, 24'h000100);
        chk("hp_none", hp_cnt, 0);

        // Asynchronous reset in the middle of a count
        repeat (5) step();
        #2 clr = 1'b0;
        #1 check_reset_pins("async");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        model_reset();

        // Preload 23:59, run to 23:59:59, then roll over
        go_hour(23);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        repeat (59) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        chk("preload_st", set_state, 2'd0);
        repeat (59 * TICK) step();
        chk("at_235959", time_bcd, 24'h235959);
        hp_cnt = 0;
        repeat (TICK) step();
        chk("rollover", time_bcd, 24'h000000);
        chk("hp_high", hour_pulse, 1'b1);
        step();
        chk("hp_once", hp_cnt, 1);
        chk("hp_low", hour_pulse, 1'b0);

        // Build 10:20:37 then exercise the editing sequence
        go_hour(10);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        repeat (20) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (37 * TICK) step();
        chk("at_102037", time_bcd, 24'h102037);
        press(1'b1, 1'b0);
        chk("set_sec_clr", time_bcd, 24'h102000);
        chk("set_hour_st", set_state, 2'd1);
        repeat (15) press(1'b0, 1'b1);
        chk("hour_wrap", time_bcd, 24'h012000);
        press(1'b1, 1'b0);
        repeat (45) press(1'b0, 1'b1);
        chk("min_wrap", time_bcd, 24'h010500);
        press(1'b1, 1'b0);
        chk("back_run", set_state, 2'd0);
        repeat (TICK - 1) step();
        chk("no_tick_yet", time_bcd, 24'h010500);
        step();
        chk("first_tick", time_bcd, 24'h010501);

        // 12-hour display
        mode_12h = 1'b1;
        check_12h(0,  7'b1001111, 7'b0010010, 1'b0, 8'h00);
        check_12h(12, 7'b1001111, 7'b0010010, 1'b1, 8'h12);
        check_12h(13, 7'h7F,      7'b1001111, 1'b1, 8'h13);
        check_12h(9,  7'h7F,      7'b0000100, 1'b0, 8'h09);
        mode_12h = 1'b0;

        // Scan order and polarity at 00:00:08, digit 0 aligned with the 8th tick
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        model_reset();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        for (int i = 0; i < 24 && !(midx == 1 && mscan == SCAN - 1); i++) step();
        press(1'b1, 1'b0);
        repeat (8 * TICK + 1) step();
        chk("scan_time", time_bcd, 24'h000008);
        chk("seg_eight", seg, 7'b0000000);
        for (int k = 0; k < 6; k++) begin
            want = ~(6'b000001 << k);
            for (int c = 0; c < SCAN; c++) begin
                chk("scan_seq", dig_sel, want);
                step();
            end
        end

        // Simultaneous buttons in SET_HOUR, then minute blink in SET_MIN
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        chk("mode_wins_st", set_state, 2'd2);
        chk("mode_wins_hr", time_bcd[23:16], 8'h00);
        nblank = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if ((dig_sel === 6'b111011 || dig_sel === 6'b110111) && mblink_seg) begin
                chk("blink_off", seg, 7'h7F);
                nblank++;
            end
        end
        chk("blink_seen", (nblank > 0), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
